// File: rtl/divider_if.sv
// Handshake bundle for the sequential divider.
// The PE datapath drives the master side; the divider sits on the slave side.
interface divider_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start,
        output a,
        output b,
        input  busy,
        input  done,
        input  quotient,
        input  remainder,
        input  div_by_zero
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        output busy,
        output done,
        output quotient,
        output remainder,
        output div_by_zero
    );
endinterface

// File: rtl/divider.sv
// Restoring shift-subtract unsigned divider, one quotient bit per clock.
// Companion to the PE array multiplier; start/busy/done handshake.
module divider #(
    parameter int WIDTH = 8
) (
    input  logic     clk,
    input  logic     rst,
    divider_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;
    localparam int         CW   = $clog2(WIDTH) + 1;

    logic [1:0]       state;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH:0]   pr;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             dbz_q;

    logic             accept;
    logic             zero;
    logic             last;
    logic             qbit;
    logic [WIDTH:0]   pr_sh;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   pr_nx;
    logic [WIDTH-1:0] dvd_nx;

    // The dividend register doubles as the quotient shift register.
    always_comb begin
        accept = bus.start && (state != RUN);
        zero   = (divisor == '0);
        last   = (cnt == CW'(WIDTH - 1));
        pr_sh  = {pr[WIDTH-1:0], dividend[WIDTH-1]};
        diff   = pr_sh - {1'b0, divisor};
        qbit   = ~diff[WIDTH];
        pr_nx  = qbit ? diff : pr_sh;
        dvd_nx = {dividend[WIDTH-2:0], qbit};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            dividend    <= '0;
            divisor     <= '0;
            pr          <= '0;
            cnt         <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            unique case (state)
                IDLE, FIN: begin
                    if (accept) begin
                        dividend <= bus.a;
                        divisor  <= bus.b;
                        pr       <= '0;
                        cnt      <= '0;
                        dbz_q    <= 1'b0;
                        state    <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    // A zero divisor skips the iterations entirely.
                    if (zero) begin
                        quotient_q  <= '1;
                        remainder_q <= dividend;
                        dbz_q       <= 1'b1;
                        state       <= FIN;
                    end else begin
                        pr       <= pr_nx;
                        dividend <= dvd_nx;
                        cnt      <= cnt + CW'(1);
                        if (last) begin
                            quotient_q  <= dvd_nx;
                            remainder_q <= pr_nx[WIDTH-1:0];
                            state       <= FIN;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy        = (state == RUN) && !zero;
    assign bus.done        = (state == FIN);
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_divider.sv
// Directed and swept checks for the 8-bit sequential divider.
module tb_divider;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    divider_if #(.WIDTH(8)) bus ();

    divider #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse start, then wait (bounded) for done; report edges and busy cycles.
    task automatic run_op(input logic [7:0] aa, input logic [7:0] bb,
                          output int edges, output int bcyc);
        bus.a = aa;
        bus.b = bb;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        edges = 0;
        bcyc = 0;
        while (!bus.done && edges < 50) begin
            if (bus.busy) bcyc++;
            step();
            edges++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (3) step();
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %0b want 0", bus.busy);
        end
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done: got %0b want 0", bus.done);
        end
        checks++;
        if (bus.quotient !== 8'd0 || bus.remainder !== 8'd0) begin
            errors++;
            $display("FAIL reset_results: got q=%0d r=%0d want 0 0",
                     bus.quotient, bus.remainder);
        end
        checks++;
        if (bus.div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_dbz: got %0b want 0", bus.div_by_zero);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int e, bc;
        run_op(8'd200, 8'd7, e, bc);
        checks++;
        if (e !== 8) begin
            errors++;
            $display("FAIL basic_latency: got %0d edges want 8", e);
        end
        checks++;
        if (bc !== 8) begin
            errors++;
            $display("FAIL basic_busy: got %0d cycles want 8", bc);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy_at_done: got %0b want 0", bus.busy);
        end
        checks++;
        if (bus.quotient !== 8'd28 || bus.remainder !== 8'd4 ||
            bus.div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: got q=%0d r=%0d z=%0b want 28 4 0",
                     bus.quotient, bus.remainder, bus.div_by_zero);
        end
        step();
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse: got %0b want 0", bus.done);
        end
        repeat (3) step();
        checks++;
        if (bus.quotient !== 8'd28 || bus.remainder !== 8'd4) begin
            errors++;
            $display("FAIL basic_hold: got q=%0d r=%0d want 28 4",
                     bus.quotient, bus.remainder);
        end
    endtask

    task automatic test_corners();
        logic [7:0] va[4] = '{8'd255, 8'd5, 8'd255, 8'd128};
        logic [7:0] vb[4] = '{8'd1, 8'd9, 8'd255, 8'd129};
        logic [7:0] vq[4] = '{8'd255, 8'd0, 8'd1, 8'd0};
        logic [7:0] vr[4] = '{8'd0, 8'd5, 8'd0, 8'd128};
        int e, bc;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], e, bc);
            checks++;
            if (e !== 8 || bus.quotient !== vq[i] || bus.remainder !== vr[i]) begin
                errors++;
                $display("FAIL corner_%0d: got e=%0d q=%0d r=%0d want 8 %0d %0d",
                         i, e, bus.quotient, bus.remainder, vq[i], vr[i]);
            end
        end
    endtask

    task automatic test_div_zero();
        int e, bc;
        run_op(8'd77, 8'd0, e, bc);
        checks++;
        if (e !== 1) begin
            errors++;
            $display("FAIL dz_latency: got %0d edges want 1", e);
        end
        checks++;
        if (bc !== 0) begin
            errors++;
            $display("FAIL dz_busy: got %0d cycles want 0", bc);
        end
        checks++;
        if (bus.quotient !== 8'd255 || bus.remainder !== 8'd77 ||
            bus.div_by_zero !== 1'b1) begin
            errors++;
            $display("FAIL dz_result: got q=%0d r=%0d z=%0b want 255 77 1",
                     bus.quotient, bus.remainder, bus.div_by_zero);
        end
        step();
        run_op(8'd9, 8'd3, e, bc);
        checks++;
        if (bus.quotient !== 8'd3 || bus.remainder !== 8'd0 ||
            bus.div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL dz_clear: got q=%0d r=%0d z=%0b want 3 0 0",
                     bus.quotient, bus.remainder, bus.div_by_zero);
        end
        step();
    endtask

    task automatic test_ignore_start();
        int e;
        bus.a = 8'd100;
        bus.b = 8'd10;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (3) step();
        bus.a = 8'd1;
        bus.b = 8'd1;
        bus.start = 1'b1;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL ign_busy: got %0b want 1", bus.busy);
        end
        step();
        bus.start = 1'b0;
        bus.a = 8'hAA;
        bus.b = 8'h55;
        e = 4;
        while (!bus.done && e < 50) begin
            step();
            e++;
        end
        checks++;
        if (e !== 8 || bus.quotient !== 8'd10 || bus.remainder !== 8'd0) begin
            errors++;
            $display("FAIL ign_result: got e=%0d q=%0d r=%0d want 8 10 0",
                     e, bus.quotient, bus.remainder);
        end
        step();
    endtask

    task automatic test_reset_abort();
        int e, bc, nd;
        bus.a = 8'd250;
        bus.b = 8'd3;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.quotient !== 8'd0 ||
            bus.remainder !== 8'd0 || bus.div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL abort_clear: got b=%0b d=%0b q=%0d r=%0d z=%0b want all 0",
                     bus.busy, bus.done, bus.quotient, bus.remainder,
                     bus.div_by_zero);
        end
        nd = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.done || bus.busy) nd++;
            step();
        end
        checks++;
        if (nd !== 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d active cycles want 0", nd);
        end
        run_op(8'd250, 8'd3, e, bc);
        checks++;
        if (e !== 8 || bus.quotient !== 8'd83 || bus.remainder !== 8'd1) begin
            errors++;
            $display("FAIL abort_rerun: got e=%0d q=%0d r=%0d want 8 83 1",
                     e, bus.quotient, bus.remainder);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int e1, e2, b2;
        bus.a = 8'd60;
        bus.b = 8'd7;
        bus.start = 1'b1;
        step();
        e1 = 0;
        while (!bus.done && e1 < 50) begin
            step();
            e1++;
        end
        checks++;
        if (e1 !== 8 || bus.quotient !== 8'd8 || bus.remainder !== 8'd4) begin
            errors++;
            $display("FAIL b2b_first: got e=%0d q=%0d r=%0d want 8 8 4",
                     e1, bus.quotient, bus.remainder);
        end
        step();
        bus.start = 1'b0;
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1 || bus.quotient !== 8'd8) begin
            errors++;
            $display("FAIL b2b_accept: got d=%0b b=%0b q=%0d want 0 1 8",
                     bus.done, bus.busy, bus.quotient);
        end
        e2 = 0;
        b2 = 0;
        while (!bus.done && e2 < 50) begin
            if (bus.busy) b2++;
            step();
            e2++;
        end
        checks++;
        if (e2 !== 8 || b2 !== 8 || bus.quotient !== 8'd8 ||
            bus.remainder !== 8'd4) begin
            errors++;
            $display("FAIL b2b_second: got e=%0d busy=%0d q=%0d r=%0d want 8 8 8 4",
                     e2, b2, bus.quotient, bus.remainder);
        end
        step();
    endtask

    task automatic test_sweep();
        logic [7:0] ra, rb, eq, er;
        logic       ez;
        int         e, bc;
        for (int i = 0; i < 3000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = (i % 64 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            if (rb == 8'd0) begin
                eq = 8'hFF;
                er = ra;
                ez = 1'b1;
            end else begin
                eq = ra / rb;
                er = ra % rb;
                ez = 1'b0;
            end
            run_op(ra, rb, e, bc);
            checks++;
            if (bus.quotient !== eq || bus.remainder !== er ||
                bus.div_by_zero !== ez || bus.done !== 1'b1) begin
                errors++;
                $display("FAIL sweep %0d/%0d: got q=%0d r=%0d z=%0b want %0d %0d %0b",
                         ra, rb, bus.quotient, bus.remainder, bus.div_by_zero,
                         eq, er, ez);
            end
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        test_reset();
        test_basic();
        test_corners();
        test_div_zero();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
